// File: rtl/pool_share_arbiter.sv
// Round-robin, frame-granular share of one maxpool_relu unit between two conv engines.
// Optional drain watchdog (drain_timeout port) enabled by defining DRAIN_TIMEOUT_EN.
module pool_share_arbiter #(
    parameter int CONV_BIT     = 12,
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 12
`ifdef DRAIN_TIMEOUT_EN
    ,
    parameter int DRAIN_LIMIT  = 64
`endif
) (
    input  logic                  gclk,
    input  logic                  rst_n,
    input  logic                  req_0,
    input  logic                  req_1,
    output logic                  grant_0,
    output logic                  grant_1,
    input  logic                  valid_0,
    input  logic                  valid_1,
    input  logic [3*CONV_BIT-1:0] data_0,
    input  logic [3*CONV_BIT-1:0] data_1,
    output logic                  pool_valid_in,
    output logic [3*CONV_BIT-1:0] pool_data,
    input  logic                  pool_busy,
    input  logic                  pool_valid_out,
    input  logic [3*CONV_BIT-1:0] pool_max,
    output logic                  out_valid,
    output logic [3*CONV_BIT-1:0] out_data,
    output logic                  out_owner,
    output logic                  frame_done,
    output logic                  done_owner,
    output logic                  err_spurious
`ifdef DRAIN_TIMEOUT_EN
    ,
    output logic                  drain_timeout
`endif
);
    localparam int IN_BEATS  = INPUT_WIDTH * INPUT_WIDTH;
    localparam int OUT_BEATS = OUTPUT_WIDTH * OUTPUT_WIDTH;
    localparam int ICW       = $clog2(IN_BEATS + 1);
    localparam int OCW       = $clog2(OUT_BEATS + 1);
    localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
    localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_BEATS);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                  state_q;
    logic                    owner_q;
    logic                    last_owner_q;
    logic                    grant_0_q;
    logic                    grant_1_q;
    logic [ICW-1:0]          in_cnt_q;
    logic [OCW-1:0]          out_cnt_q;
    logic [OCW-1:0]          out_cnt_d;
    logic                    out_valid_q;
    logic [3*CONV_BIT-1:0]   out_data_q;
    logic                    out_owner_q;
    logic                    frame_done_q;
    logic                    done_owner_q;
    logic                    err_q;
    logic                    req_any;
    logic                    pick_d;
    logic                    own_valid;
    logic                    beat_acc;
    logic                    drain_ok;

`ifdef DRAIN_TIMEOUT_EN
    localparam int DCW = $clog2(DRAIN_LIMIT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LIMIT - 1);
    logic [DCW-1:0]          drain_cnt_q;
    logic                    drain_to_q;
    assign drain_timeout = drain_to_q;
`endif

    // On a tie the requester that did not own the last frame wins
    assign req_any   = req_0 | req_1;
    assign pick_d    = (req_0 & req_1) ? ~last_owner_q : req_1;

    assign own_valid = owner_q ? (valid_1 & grant_1_q) : (valid_0 & grant_0_q);
    assign beat_acc  = (state_q == STREAM) & own_valid;
    assign drain_ok  = (out_cnt_q == OUT_FULL) & ~pool_busy;

    assign out_cnt_d = (pool_valid_out && out_cnt_q != OUT_FULL)
                     ? out_cnt_q + 1'b1 : out_cnt_q;

    assign pool_valid_in = beat_acc;
    assign pool_data     = beat_acc ? (owner_q ? data_1 : data_0) : '0;
    assign grant_0       = grant_0_q;
    assign grant_1       = grant_1_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_owner     = out_owner_q;
    assign frame_done    = frame_done_q;
    assign done_owner    = done_owner_q;
    assign err_spurious  = err_q;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            grant_0_q    <= 1'b0;
            grant_1_q    <= 1'b0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_owner_q  <= 1'b0;
            frame_done_q <= 1'b0;
            done_owner_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
            drain_cnt_q  <= '0;
            drain_to_q   <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
            drain_to_q   <= 1'b0;
`endif
            out_valid_q  <= pool_valid_out;
            out_cnt_q    <= out_cnt_d;
            if (pool_valid_out) begin
                out_data_q  <= pool_max;
                out_owner_q <= (state_q == IDLE) ? last_owner_q : owner_q;
                if (state_q == IDLE)
                    err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        owner_q   <= pick_d;
                        grant_0_q <= ~pick_d;
                        grant_1_q <= pick_d;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_acc) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (in_cnt_q == IN_LAST) begin
                            grant_0_q <= 1'b0;
                            grant_1_q <= 1'b0;
                            state_q   <= DRAIN;
`ifdef DRAIN_TIMEOUT_EN
                            drain_cnt_q <= '0;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        frame_done_q <= 1'b1;
                        done_owner_q <= owner_q;
                        last_owner_q <= owner_q;
                        state_q      <= IDLE;
                    end
`ifdef DRAIN_TIMEOUT_EN
                    else if (drain_cnt_q == DRAIN_LAST) begin
                        frame_done_q <= 1'b1;
                        drain_to_q   <= 1'b1;
                        done_owner_q <= owner_q;
                        last_owner_q <= owner_q;
                        state_q      <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_share_arbiter.sv
// Scoreboard bench for pool_share_arbiter with a 4-beats-per-output pool model.
// Covers arbitration, muxing, drain, spurious output, reset and optional drain watchdog.
module tb_pool_share_arbiter;
    localparam int CB = 12;
    localparam int NB = 576;
    localparam int NO = 144;

    logic          gclk = 1'b0;
    logic          rst_n;
    logic          req_0, req_1, valid_0, valid_1;
    logic [35:0]   data_0, data_1;
    logic          grant_0, grant_1, pool_valid_in;
    logic [35:0]   pool_data, pool_max, out_data;
    logic          pool_busy, pool_valid_out;
    logic          out_valid, out_owner, frame_done, done_owner, err_spurious;
`ifdef DRAIN_TIMEOUT_EN
    logic          drain_timeout;
`endif

    pool_share_arbiter #(.CONV_BIT(CB), .INPUT_WIDTH(24), .OUTPUT_WIDTH(12)) dut (
        .gclk(gclk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1),
        .grant_0(grant_0), .grant_1(grant_1),
        .valid_0(valid_0), .valid_1(valid_1),
        .data_0(data_0), .data_1(data_1),
        .pool_valid_in(pool_valid_in), .pool_data(pool_data),
        .pool_busy(pool_busy), .pool_valid_out(pool_valid_out),
        .pool_max(pool_max),
        .out_valid(out_valid), .out_data(out_data), .out_owner(out_owner),
        .frame_done(frame_done), .done_owner(done_owner),
        .err_spurious(err_spurious)
`ifdef DRAIN_TIMEOUT_EN
        , .drain_timeout(drain_timeout)
`endif
    );

    always #5 gclk = ~gclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ov = 0;
    int pv_cnt = 0;
    int lim = NO;
    logic [36:0] sb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] dfn(input int r, input int k);
        return {12'(k), 12'(r + 7), 12'(k * 5 + r)};
    endfunction

    // Pool model: one result per 4 accepted beats, busy while a result is pending
    logic [1:0]  mb;
    logic [7:0]  mo;
    logic        pv_q, inj;
    logic [35:0] pm_q, inj_d;
    assign pool_valid_out = pv_q | inj;
    assign pool_max       = inj ? inj_d : pm_q;
    assign pool_busy      = pv_q;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            mb <= '0; mo <= '0; pv_q <= 1'b0; pm_q <= '0;
        end else begin
            pv_q <= 1'b0;
            if (frame_done) mo <= '0;
            if (pool_valid_in) begin
                mb <= mb + 1'b1;
                if (mb == 2'd3 && int'(mo) < lim) begin
                    pv_q <= 1'b1;
                    pm_q <= pool_data;
                    mo   <= mo + 1'b1;
                end
            end
        end
    end

    always @(posedge gclk) cyc++;

    logic [36:0] e;
    always @(negedge gclk) begin
        if (rst_n === 1'b1) begin
            check("grant_mutex", {63'd0, grant_0 & grant_1}, 64'd0);
            if (pool_valid_in) pv_cnt++;
            if (out_valid) begin
                last_ov = cyc;
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", {27'd0, out_owner, out_data}, 64'h1FFFFFFFFF);
                end else begin
                    e = sb.pop_front();
                    check("out_owner_data", {27'd0, out_owner, out_data}, {27'd0, e});
                end
            end
        end
    end

    task automatic run_frame(input int r, input bit rearm, input int nb);
        int w;
        int pushed;
        logic g_own, g_oth;
        pushed = 0;
        if (r == 1) req_1 = 1'b1; else req_0 = 1'b1;
        w = 0;
        do begin
            @(negedge gclk);
            w++;
            g_own = (r == 1) ? grant_1 : grant_0;
        end while (!g_own && w < 20);
        check("grant_seen", {63'd0, g_own}, 64'd1);
        g_oth = (r == 1) ? grant_0 : grant_1;
        check("grant_other", {63'd0, g_oth}, 64'd0);
        pv_cnt = 0;
        for (int k = 0; k < nb; k++) begin
            @(posedge gclk); #1;
            if (k == 0 && !rearm) begin
                if (r == 1) req_1 = 1'b0; else req_0 = 1'b0;
            end
            if (r == 1) begin
                valid_1 = 1'b1; data_1 = dfn(r, k);
                valid_0 = 1'b1; data_0 = 36'hABC;
            end else begin
                valid_0 = 1'b1; data_0 = dfn(r, k);
                valid_1 = 1'b1; data_1 = 36'hABC;
            end
            if (k % 4 == 3 && pushed < lim) begin
                sb.push_back({r[0], dfn(r, k)});
                pushed++;
            end
            @(negedge gclk);
            g_own = (r == 1) ? grant_1 : grant_0;
            g_oth = (r == 1) ? grant_0 : grant_1;
            check("beat", {25'd0, g_own, g_oth, pool_valid_in, pool_data},
                  {25'd0, 1'b1, 1'b0, 1'b1, dfn(r, k)});
        end
        if (nb < NB) return;
        @(posedge gclk); #1;
        if (r == 1) data_1 = dfn(r, NB); else data_0 = dfn(r, NB);
        @(negedge gclk);
        g_own = (r == 1) ? grant_1 : grant_0;
        check("beat_after_last", {62'd0, pool_valid_in, g_own}, 64'd0);
        w = cyc;
        @(posedge gclk); #1;
        valid_0 = 1'b0; valid_1 = 1'b0; data_0 = '0; data_1 = '0;
        for (int t = 0; t < 200 && frame_done !== 1'b1; t++) @(negedge gclk);
        check("frame_done", {63'd0, frame_done}, 64'd1);
        check("done_owner", {63'd0, done_owner}, 64'(r));
        check("in_beats", 64'(pv_cnt), 64'(NB));
        if (lim == NO) begin
            check("done_latency", 64'(cyc - last_ov), 64'd1);
`ifdef DRAIN_TIMEOUT_EN
            check("no_timeout", {63'd0, drain_timeout}, 64'd0);
`endif
        end else begin
            check("timeout_cycles", 64'(cyc - w), 64'd64);
`ifdef DRAIN_TIMEOUT_EN
            check("drain_timeout", {63'd0, drain_timeout}, 64'd1);
`endif
        end
    endtask

    task automatic pulse_reset();
        @(posedge gclk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge gclk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_0 = 0; req_1 = 0; valid_0 = 0; valid_1 = 0;
        data_0 = '0; data_1 = '0; inj = 0; inj_d = '0;
        repeat (3) @(posedge gclk);
        @(negedge gclk);
        check("reset_ctl", {56'd0, grant_0, grant_1, pool_valid_in, out_valid,
              out_owner, frame_done, done_owner, err_spurious}, 64'd0);
        check("reset_data", {28'd0, out_data}, 64'd0);
        @(posedge gclk); #1;
        rst_n = 1'b1;

        // Single requester
        run_frame(0, 1'b0, NB);

        // Both requesting from reset: 0, 1, 0
        pulse_reset();
        req_1 = 1'b1;
        run_frame(0, 1'b1, NB);
        run_frame(1, 1'b0, NB);
        run_frame(0, 1'b0, NB);

        // Spurious pooled output while idle
        @(posedge gclk); #1;
        inj = 1'b1; inj_d = 36'h123456789;
        sb.push_back({1'b0, 36'h123456789});
        @(posedge gclk); #1;
        inj = 1'b0;
        @(negedge gclk);
        check("err_set", {63'd0, err_spurious}, 64'd1);
        repeat (5) @(negedge gclk);
        check("err_sticky", {63'd0, err_spurious}, 64'd1);

        // Reset in the middle of a frame
        run_frame(0, 1'b0, 300);
        @(posedge gclk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge gclk);
        check("midreset_ctl", {56'd0, grant_0, grant_1, pool_valid_in, out_valid,
              out_owner, frame_done, done_owner, err_spurious}, 64'd0);
        check("midreset_data", {28'd0, out_data}, 64'd0);
        valid_0 = 1'b0; valid_1 = 1'b0; req_0 = 1'b0;
        @(posedge gclk); #1;
        rst_n = 1'b1;
        run_frame(1, 1'b0, NB);

`ifdef DRAIN_TIMEOUT_EN
        lim = 100;
        run_frame(0, 1'b0, NB);
        lim = NO;
`endif
        repeat (4) @(negedge gclk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
